// File: rtl/psum_drain.sv
// psum_drain: row FIFO plus column serializer between the core and the readback stream.
// Optional build macro PSUM_DRAIN_RELU_EN clamps negative output words to zero.
module psum_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [psum_bw*col-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [psum_bw-1:0]         out_data,
    output logic [$clog2(col)-1:0]     out_col,
    output logic                       out_last,
    output logic [$clog2(depth):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int CW = $clog2(col);
    localparam int PW = $clog2(depth);
    localparam int NW = PW + 1;
    localparam int RW = psum_bw * col;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state;
    logic [RW-1:0]   mem [depth];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   nextRdPtr;
    logic [NW-1:0]   nextCount;
    logic [CW-1:0]   nextCol;
    logic [RW-1:0]   nextHead;
    logic [psum_bw-1:0] nextSel;
    logic [psum_bw-1:0] nextWord;
    logic            handshake;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;

    always_comb begin
        handshake = (state == DRAIN) && out_ready;
        pop       = handshake && out_last;
        full      = fifo_count == NW'(depth);
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
        nextCount = fifo_count + NW'(push) - NW'(pop);
        nextRdPtr = pop ? rdPtr + 1'b1 : rdPtr;
        nextCol   = out_col;
        if (handshake) begin
            nextCol = pop ? '0 : out_col + 1'b1;
        end
        // A row landing on the next head slot this cycle is not in mem yet.
        nextHead  = (push && wrPtr == nextRdPtr) ? in_data : mem[nextRdPtr];
        nextSel   = nextHead[psum_bw*nextCol +: psum_bw];
`ifdef PSUM_DRAIN_RELU_EN
        nextWord  = nextSel[psum_bw-1] ? '0 : nextSel;
`else
        nextWord  = nextSel;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr      <= nextRdPtr;
            fifo_count <= nextCount;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (nextCount != '0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_data  <= nextWord;
                out_col   <= nextCol;
                out_last  <= nextCol == CW'(col - 1);
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_col   <= '0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Downstream stage of the core: captures each `col`-wide psum row that the core emits (`coreOut` qualified by `valid`) into a small FIFO and serializes it one column at a time onto a psum_bw-wide valid/ready stream toward the host/testbench readback path. It decouples the core's single-cycle output pulses from a slower consumer. It flags any row lost to backpressure.

## Interface
Parameters:
- col, 8, columns per row (power of 2)
- psum_bw, 16, bits per column psum (signed two's complement)
- depth, 4, FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  core output valid; one-cycle qualifier for in_data
- in_data  in  psum_bw*col  core output row; column c at bits [psum_bw*c +: psum_bw]
- out_valid  out  1  out_data/out_col/out_last valid
- out_ready  in  1  consumer accepts current word
- out_data  out  psum_bw  serialized column psum
- out_col  out  $clog2(col)  column index of out_data
- out_last  out  1  high on column col-1 of a row
- fifo_count  out  $clog2(depth)+1  rows held, including the one draining
- overflow  out  1  sticky: a row was dropped
- clear_ovf  in  1  synchronous clear of overflow

## Operation
- FIFO: depth × (psum_bw*col) storage, wr_ptr/rd_ptr with wrap modulo depth, count register 0..depth.
- Push: `in_valid && (count<depth || pop)` writes in_data at wr_ptr. `pop` = the last column of the head row handshakes this cycle. Push and pop in the same cycle leave count unchanged.
- Drop: `in_valid && count==depth && !pop` discards the row and sets overflow. Pointers and count are unchanged.
- overflow: set has priority over clear_ovf in the same cycle. It is cleared only by clear_ovf or reset.
- Serializer FSM:
  - IDLE: out_valid=0, col_idx=0. Moves to DRAIN when count>0.
  - DRAIN: out_valid=1, out_data = head row column col_idx, out_col=col_idx, out_last=(col_idx==col-1).
    - On a handshake (out_valid && out_ready) with col_idx<col-1: col_idx+1.
    - On a handshake with col_idx==col-1: pop, col_idx=0. Stays in DRAIN if count after the update is >0, otherwise goes to IDLE.
    - No handshake: hold.
- Column order: 0 first, col-1 last. A row is never split or reordered.
- Exactly col handshakes per accepted row.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_col=0, out_last=0
  - fifo_count=0, overflow=0, FSM=IDLE, pointers=0
  - FIFO storage contents are not reset.
- Reset mid-drain: all queued rows are discarded and no further words are emitted.
- out_data/out_col/out_last are registered.
- Latency: a row pushed into an empty FIFO in cycle N gives out_valid=1 with column 0 in cycle N+1.
- Throughput: one word per cycle with out_ready held high. Back-to-back rows drain with no bubble between column col-1 and the next column 0.
- Stability: while out_valid=1 and out_ready=0, out_data/out_col/out_last must not change. out_valid must not drop until the handshake.
- out_ready is ignored when out_valid=0.
- fifo_count reflects registered count; it is updated the cycle after a push or pop.
- Wrap-around: pointers roll from depth-1 to 0 with no loss.

## Configuration
- PSUM_DRAIN_RELU_EN defined: out_data = 0 when the selected psum is negative (MSB=1), otherwise the psum. ReLU is applied on the output mux, so FIFO contents are unmodified.
- Not defined: out_data is the raw psum bit-for-bit.
- Flags, handshake and latency are identical in both builds.

## Test plan
- Single row, column c = c+1 (0x0001..0x0008), out_ready=1:
  - out_valid rises the cycle after in_valid.
  - Eight consecutive words 0x0001..0x0008 with out_col 0..7.
  - out_last only on 0x0008; then IDLE, fifo_count=0.
- Backpressure: out_ready toggles 1,0,0,1,…
  - Words are held stable during the stalls.
  - All 8 columns arrive in order, with no duplicates or skips.
- Overflow: out_ready=0, push 5 rows (depth=4).
  - fifo_count=4 and overflow=1 after row 5.
  - With out_ready=1: only rows 1–4 drain.
  - clear_ovf=1 then gives overflow=0.
- Full with simultaneous pop: count=4, row 5 pushed in the same cycle the head's out_last handshakes.
  - Row 5 is accepted, count stays 4, overflow stays 0.
  - Over 10 rows, pointer wrap shows no corruption.
- Reset mid-drain: reset=0 at column 3 of row 2.
  - All outputs return to reset values and queued rows are lost.
  - After release, a new row drains from column 0.
- ReLU: column 0 = 0xFFF0, column 1 = 0x0010.
  - With PSUM_DRAIN_RELU_EN: 0x0000, 0x0010.
  - Without: 0xFFF0, 0x0010.
